data_frame_capture: RTL

//   Parametrised successor to the start-triggered sample latch: captures STAGE consecutive

---
 rtl/data_frame_capture.sv | 114 +++++++++++
 1 files changed

// File: rtl/data_frame_capture.sv
// Frame capture: collects STAGE valid multi-channel samples into a working buffer,
// then publishes the complete frame to data_q with a one-cycle frame_valid pulse.
//
// state     | meaning
// S_IDLE    | waiting for start; samples ignored
// S_CAPTURE | accepting valid samples into work buffer slot idx
module data_frame_capture #(
  parameter int STAGE  = 8,
  parameter int DWIDTH = 8,
  parameter int NCH    = 1,
  parameter int FCW    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          mode_cont,
  input  logic                          abort,
  input  logic                          in_valid,
  input  logic [NCH*DWIDTH-1:0]         data,
  output logic                          busy,
  output logic                          last_sample,
  output logic                          frame_valid,
  output logic [FCW-1:0]                frame_cnt,
  output logic [STAGE*NCH*DWIDTH-1:0]   data_q
);

  localparam int SW   = NCH * DWIDTH;
  localparam int FW   = STAGE * SW;
  localparam int IDXW = (STAGE > 1) ? $clog2(STAGE) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(STAGE - 1);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_CAPTURE = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            mode_q, mode_d;
  logic [FW-1:0]   work_q, work_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic            fv_q, fv_d;
  logic [FCW-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      work_q  <= '0;
      frame_q <= '0;
      fv_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      work_q  <= work_d;
      frame_q <= frame_d;
      fv_q    <= fv_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    work_d  = work_q;
    frame_d = frame_q;
    fv_d    = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_CAPTURE;
          idx_d   = '0;
          mode_d  = mode_cont;
        end
      end

      S_CAPTURE: begin
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (in_valid) begin
          for (int s = 0; s < STAGE; s++) begin
            if (idx_q == IDXW'(s)) work_d[s*SW +: SW] = data;
          end
          if (idx_q == IDX_LAST) begin
            // publish the frame including the sample written just above
            frame_d = work_d;
            fv_d    = 1'b1;
            cnt_d   = cnt_q + FCW'(1);
            idx_d   = '0;
            if (!mode_q) state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q == S_CAPTURE);
  assign last_sample = (state_q == S_CAPTURE) && (idx_q == IDX_LAST);
  assign frame_valid = fv_q;
  assign frame_cnt   = cnt_q;
  assign data_q      = frame_q;

endmodule
